// File: rtl/filtro_secuenciador.sv
`default_nettype none
// ============================================================================
//  Module   : filtro_secuenciador
//  Brief    : Per-sample control FSM for an enable-gated FIR datapath.
//             Each accepted start issues: load input, clear accumulator,
//             TAPS MAC steps, load output, shift delay line, done pulse.
//             A start seen while a sequence runs sets a sticky overrun flag.
//  Revision : 1.0 - initial release
// ============================================================================
module filtro_secuenciador #(
    parameter int TAPS  = 3,
    parameter int SEL_W = 2
) (
    input  logic             clk44kHz,
    input  logic             reset,
    input  logic             start,
    input  logic             ovr_clr,
    output logic             en_x,
    output logic             acc_clr,
    output logic             en_acc,
    output logic [SEL_W-1:0] tap_sel,
    output logic             en_y,
    output logic             en_delay,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_X = 3'd1;
    localparam logic [2:0] MAC    = 3'd2;
    localparam logic [2:0] LOAD_Y = 3'd3;
    localparam logic [2:0] SHIFT  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    // Index of the final MAC step; MAC exits when the tap counter reaches it.
    localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(TAPS - 1);

    logic [2:0]       state;
    logic [SEL_W-1:0] tap_cnt;

    // Sequence state and tap counter; start is only honoured from IDLE.
    always_ff @(posedge clk44kHz or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_X;
                    end
                end
                LOAD_X: begin
                    tap_cnt <= '0;
                    state   <= MAC;
                end
                MAC: begin
                    if (tap_cnt == LAST_TAP) begin
                        tap_cnt <= '0;
                        state   <= LOAD_Y;
                    end else begin
                        tap_cnt <= tap_cnt + SEL_W'(1);
                    end
                end
                LOAD_Y:  state <= SHIFT;
                SHIFT:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overrun: a start seen outside IDLE sets it, and setting beats clearing.
    always_ff @(posedge clk44kHz or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (start && (state != IDLE)) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    // Moore output decode from the state register and tap counter only.
    always_comb begin
        en_x     = 1'b0;
        acc_clr  = 1'b0;
        en_acc   = 1'b0;
        tap_sel  = '0;
        en_y     = 1'b0;
        en_delay = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            LOAD_X: begin
                en_x    = 1'b1;
                acc_clr = 1'b1;
            end
            MAC: begin
                en_acc  = 1'b1;
                tap_sel = tap_cnt;
            end
            LOAD_Y:  en_y     = 1'b1;
            SHIFT:   en_delay = 1'b1;
            DONE:    done     = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_filtro_secuenciador.sv
`default_nettype none
// ============================================================================
//  Module   : tb_filtro_secuenciador
//  Brief    : Directed self-checking bench for filtro_secuenciador
//             (TAPS=3 instance plus a TAPS=1 instance).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_filtro_secuenciador;

    logic clk44kHz = 1'b0;
    always #5 clk44kHz = ~clk44kHz;

    // TAPS=3 instance
    logic       reset, start, ovr_clr;
    logic       en_x, acc_clr, en_acc, en_y, en_delay, busy, done, overrun;
    logic [1:0] tap_sel;

    // TAPS=1 instance
    logic       reset1, start1, ovr_clr1;
    logic       en_x1, acc_clr1, en_acc1, en_y1, en_delay1, busy1, done1, overrun1;
    logic [0:0] tap_sel1;

    int errors = 0;
    int checks = 0;

    filtro_secuenciador #(.TAPS(3), .SEL_W(2)) dut (
        .clk44kHz(clk44kHz), .reset(reset), .start(start), .ovr_clr(ovr_clr),
        .en_x(en_x), .acc_clr(acc_clr), .en_acc(en_acc), .tap_sel(tap_sel),
        .en_y(en_y), .en_delay(en_delay), .busy(busy), .done(done), .overrun(overrun)
    );

    filtro_secuenciador #(.TAPS(1), .SEL_W(1)) dut1 (
        .clk44kHz(clk44kHz), .reset(reset1), .start(start1), .ovr_clr(ovr_clr1),
        .en_x(en_x1), .acc_clr(acc_clr1), .en_acc(en_acc1), .tap_sel(tap_sel1),
        .en_y(en_y1), .en_delay(en_delay1), .busy(busy1), .done(done1), .overrun(overrun1)
    );

    // Observed vector: {en_x, acc_clr, en_acc, tap_sel[1:0], en_y, en_delay, busy, done, overrun}
    logic [9:0] obs, obs1;
    assign obs  = {en_x, acc_clr, en_acc, tap_sel, en_y, en_delay, busy, done, overrun};
    assign obs1 = {en_x1, acc_clr1, en_acc1, 1'b0, tap_sel1, en_y1, en_delay1, busy1, done1, overrun1};

    // Expected vector for a phase: 0 idle, 1 load_x, 2 mac, 3 load_y, 4 shift, 5 done.
    function automatic logic [9:0] mk(input int ph, input int sel, input logic ov);
        logic [9:0] v;
        v = '0;
        case (ph)
            1: v = 10'b11_0_00_00_1_0_0;
            2: v = {3'b001, 2'(sel), 5'b00100};
            3: v = 10'b00_0_00_10_1_0_0;
            4: v = 10'b00_0_00_01_1_0_0;
            5: v = 10'b00_0_00_00_1_1_0;
            default: v = '0;
        endcase
        v[0] = ov;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk44kHz);
        #1;
    endtask

    // Full TAPS=3 sequence from IDLE, checking cycles 1..8. During cycle inj
    // (if nonzero) start is raised, optionally together with ovr_clr.
    task automatic seq(input string name, input logic ov0, input int inj, input logic clr_also);
        int ph, sel;
        logic ov;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            sel = 0;
            if (c == 1)      ph = 1;
            else if (c <= 4) begin ph = 2; sel = c - 2; end
            else if (c == 5) ph = 3;
            else if (c == 6) ph = 4;
            else if (c == 7) ph = 5;
            else             ph = 0;
            ov = (inj > 0 && c > inj) ? 1'b1 : ov0;
            chk($sformatf("%s c%0d", name, c), obs, mk(ph, sel, ov));
            if (c == inj) begin
                start   = 1'b1;
                ovr_clr = clr_also;
            end else begin
                start   = 1'b0;
                ovr_clr = 1'b0;
            end
            if (c < 8) step();
        end
    endtask

    initial begin
        int n_done, n_busy;
        logic [9:0] exp1 [1:6];

        reset = 1'b1; start = 1'b0; ovr_clr = 1'b0;
        reset1 = 1'b1; start1 = 1'b0; ovr_clr1 = 1'b0;
        #1;
        chk("reset_hold", obs, '0);
        step();
        step();
        reset = 1'b0;
        reset1 = 1'b0;
        step();
        chk("reset_idle", obs, '0);
        chk("reset_idle_t1", obs1, '0);

        // Single sequence timing
        seq("single", 1'b0, 0, 1'b0);

        // Back-to-back starts every TAPS+5 cycles
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                n_done += int'(done);
                n_busy += int'(busy);
                if (c < 8) step();
            end
        end
        checks++;
        assert (n_done == 10) else begin
            errors++;
            $error("FAIL b2b_done observed=%0d expected=%0d", n_done, 10);
        end
        checks++;
        assert (n_busy == 70) else begin
            errors++;
            $error("FAIL b2b_busy observed=%0d expected=%0d", n_busy, 70);
        end
        chk1("b2b_overrun", overrun, 1'b0);

        // Start during MAC: sequence unaffected, overrun from cycle 5, then clear
        seq("ovr_mac", 1'b0, 4, 1'b0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_cleared", obs, mk(0, 0, 1'b0));

        // Overrun event and clear on the same edge: set wins
        seq("ovr_setwins", 1'b0, 4, 1'b1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_cleared2", obs, mk(0, 0, 1'b0));

        // Start sampled in DONE is dropped and flags overrun
        seq("ovr_done", 1'b0, 7, 1'b0);
        step();
        chk("done_start_dropped", obs, mk(0, 0, 1'b1));

        // Asynchronous reset during MAC with tap_sel=1 (overrun still set)
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_reset_mac1", obs, mk(2, 1, 1'b1));
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", obs, '0);
        @(posedge clk44kHz);
        #1;
        reset = 1'b0;
        step();
        chk("post_reset_idle", obs, '0);
        seq("post_reset", 1'b0, 0, 1'b0);

        // TAPS=1 instance
        exp1[1] = 10'b11_0_00_00_1_0_0;
        exp1[2] = 10'b00_1_00_00_1_0_0;
        exp1[3] = 10'b00_0_00_10_1_0_0;
        exp1[4] = 10'b00_0_00_01_1_0_0;
        exp1[5] = 10'b00_0_00_00_1_1_0;
        exp1[6] = 10'b00_0_00_00_0_0_0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("taps1 c%0d", c), obs1, exp1[c]);
            if (c < 6) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
